// File: rtl/mem_port_arb.sv
`default_nettype none
// mem_port_arb: shares one word-wide memory bus between an instruction-fetch port
// and a load/store data port, with lane steering, load extension and a bus timeout.
module mem_port_arb #(
   parameter int TIMEOUT   = 16,
   parameter int MAX_D_RUN = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_ack_o,
   output logic [31:0] if_rdata_o,
   output logic        if_err_o,
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   input  logic [3:0]  d_op_i,
   output logic        d_ack_o,
   output logic [31:0] d_rdata_o,
   output logic        d_err_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        stallreq_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int RUN_W = $clog2(MAX_D_RUN + 1);

   state_t           state, state_nxt;
   logic             sel_d;
   logic [3:0]       op_q;
   logic [1:0]       lane_q;
   logic [31:0]      rdata_q;
   logic             err_q;
   logic [RUN_W-1:0] run_cnt;
   logic [7:0]       wait_cnt;

   logic             grant_f, grant_d, d_bad, d_store, wait_expired;
   logic [3:0]       be_calc;
   logic [31:0]      wdata_calc, load_val, lane_shift;
   logic             unused_in;

   // Store direction comes from the opcode; d_we_i is redundant with it.
   assign unused_in = &{1'b0, if_addr_i[1:0], d_we_i};

   assign grant_f = if_req_i & (~d_req_i | (run_cnt == RUN_W'(MAX_D_RUN)));
   assign grant_d = d_req_i & ~grant_f;
   assign wait_expired = (wait_cnt == 8'(TIMEOUT - 1));

   always_comb begin
      d_bad      = 1'b0;
      d_store    = 1'b0;
      be_calc    = 4'hF;
      wdata_calc = d_wdata_i;
      case (d_op_i)
         4'd1, 4'd4: d_bad = 1'b0;
         4'd2, 4'd5: d_bad = d_addr_i[0];
         4'd3:       d_bad = |d_addr_i[1:0];
         4'd6: begin
            d_store    = 1'b1;
            be_calc    = 4'b0001 << d_addr_i[1:0];
            wdata_calc = {4{d_wdata_i[7:0]}};
         end
         4'd7: begin
            d_bad      = d_addr_i[0];
            d_store    = 1'b1;
            be_calc    = d_addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{d_wdata_i[15:0]}};
         end
         4'd8: begin
            d_bad   = |d_addr_i[1:0];
            d_store = 1'b1;
         end
         default: d_bad = 1'b1;
      endcase
   end

   // Lane select and extension of the captured read word for data loads.
   always_comb begin
      lane_shift = bus_rdata_i >> {lane_q, 3'b000};
      case (op_q)
         4'd1:    load_val = {{24{lane_shift[7]}}, lane_shift[7:0]};
         4'd2:    load_val = {{16{lane_shift[15]}}, lane_shift[15:0]};
         4'd3:    load_val = bus_rdata_i;
         4'd4:    load_val = {24'd0, lane_shift[7:0]};
         4'd5:    load_val = {16'd0, lane_shift[15:0]};
         default: load_val = 32'd0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_d && d_bad)         state_nxt = RESP;
            else if (grant_d || grant_f)  state_nxt = XFER;
         end
         XFER: if (bus_ack_i || wait_expired) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sel_d       <= 1'b0;
         op_q        <= 4'd0;
         lane_q      <= 2'd0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
         wait_cnt    <= 8'd0;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= 32'd0;
         bus_be_o    <= 4'd0;
         bus_wdata_o <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d || grant_f) begin
                  sel_d    <= grant_d;
                  op_q     <= grant_d ? d_op_i : 4'd0;
                  lane_q   <= d_addr_i[1:0];
                  rdata_q  <= 32'd0;
                  err_q    <= grant_d & d_bad;
                  wait_cnt <= 8'd0;
                  if (!(grant_d && d_bad)) begin
                     bus_req_o   <= 1'b1;
                     bus_we_o    <= grant_d & d_store;
                     bus_addr_o  <= grant_d ? {d_addr_i[31:2], 2'b00} : {if_addr_i[31:2], 2'b00};
                     bus_be_o    <= grant_d ? be_calc : 4'hF;
                     bus_wdata_o <= grant_d ? wdata_calc : 32'd0;
                  end
               end
            end
            XFER: begin
               if (bus_ack_i) begin
                  bus_req_o <= 1'b0;
                  rdata_q   <= sel_d ? load_val : bus_rdata_i;
               end else if (wait_expired) begin
                  bus_req_o <= 1'b0;
                  err_q     <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Counts data grants won while a fetch is kept waiting.
   always_ff @(posedge clk_i) begin
      if (rst_i || !if_req_i)                    run_cnt <= '0;
      else if (state == IDLE && grant_f)         run_cnt <= '0;
      else if (state == IDLE && grant_d)         run_cnt <= run_cnt + RUN_W'(1);
   end

   assign d_ack_o    = (state == RESP) &  sel_d;
   assign if_ack_o   = (state == RESP) & ~sel_d;
   assign d_err_o    = d_ack_o & err_q;
   assign if_err_o   = if_ack_o & err_q;
   assign d_rdata_o  = d_ack_o  ? rdata_q : 32'd0;
   assign if_rdata_o = if_ack_o ? rdata_q : 32'd0;
   assign stallreq_o = d_req_i & ~d_ack_o;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arb.sv
`default_nettype none
// tb_mem_port_arb: randomized and directed scoreboard bench for mem_port_arb.
module tb_mem_port_arb;
   localparam int TIMEOUT   = 16;
   localparam int MAX_D_RUN = 4;
   localparam byte GD = 8'd68;
   localparam byte GF = 8'd70;

   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic        if_req_i = 0, d_req_i = 0, d_we_i = 0, bus_ack_i = 0;
   logic [31:0] if_addr_i = 0, d_addr_i = 0, d_wdata_i = 0, bus_rdata_i = 0;
   logic [3:0]  d_op_i = 0;
   logic        if_ack_o, if_err_o, d_ack_o, d_err_o, bus_req_o, bus_we_o, stallreq_o;
   logic [31:0] if_rdata_o, d_rdata_o, bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_be_o;

   mem_port_arb #(.TIMEOUT(TIMEOUT), .MAX_D_RUN(MAX_D_RUN)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o),
      .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_op_i(d_op_i), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
      .bus_rdata_i(bus_rdata_i), .stallreq_o(stallreq_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      logic        has_bus;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        dead;
   } exp_t;

   exp_t dq[$];
   exp_t fq[$];
   byte  glog[$];
   int   n_chk = 0, n_fail = 0, unexp_acks = 0;
   bit   bus_dead = 0, stray_ack = 0, force_en = 0;
   logic [31:0] force_val = 0;
   int   min_wait = 0, max_wait = 0;

   task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (force_en) return force_val;
      return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
   endfunction

   // Reference model for one data access, from the opcode table.
   function automatic exp_t model_d(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w);
      exp_t e;
      logic [31:0] word, b, h;
      bit bad;
      e = '{default: 0};
      bad = (op == 0) || (op > 8) ||
            ((op == 2 || op == 5 || op == 7) && a[0]) ||
            ((op == 3 || op == 8) && a[1:0] != 0);
      if (bad) begin
         e.err = 1;
         return e;
      end
      e.has_bus = 1;
      e.we      = (op >= 6);
      e.addr    = a & ~32'h3;
      e.dead    = bus_dead;
      case (op)
         6:       e.be = 4'b0001 << a[1:0];
         7:       e.be = a[1] ? 4'hC : 4'h3;
         default: e.be = 4'hF;
      endcase
      case (op)
         6:       e.wdata = {24'd0, w[7:0]} * 32'h01010101;
         7:       e.wdata = {16'd0, w[15:0]} * 32'h00010001;
         default: e.wdata = w;
      endcase
      if (bus_dead) begin
         e.err = 1;
         return e;
      end
      word = mem_word(e.addr);
      b = (word >> (8 * a[1:0])) & 32'hFF;
      h = (word >> (16 * a[1])) & 32'hFFFF;
      case (op)
         1:       e.rdata = (b >= 128) ? b - 256 : b;
         2:       e.rdata = (h >= 32768) ? h - 65536 : h;
         3:       e.rdata = word;
         4:       e.rdata = b;
         5:       e.rdata = h;
         default: e.rdata = 0;
      endcase
      return e;
   endfunction

   function automatic exp_t model_f(input logic [31:0] a);
      exp_t e;
      e = '{default: 0};
      e.has_bus = 1;
      e.addr    = a & ~32'h3;
      e.be      = 4'hF;
      e.dead    = bus_dead;
      e.err     = bus_dead;
      e.rdata   = bus_dead ? 32'd0 : mem_word(e.addr);
      return e;
   endfunction

   // Bus slave: random wait states, optional dead bus and stray acks while idle.
   int wcnt = 0, cur_wait = 0;
   always @(negedge clk_i) begin
      bus_rdata_i = $urandom;
      bus_ack_i   = 1'b0;
      if (bus_req_o) begin
         if (!bus_dead) begin
            if (wcnt >= cur_wait) begin
               bus_ack_i   = 1'b1;
               bus_rdata_i = mem_word(bus_addr_o);
            end else wcnt++;
         end
      end else begin
         wcnt      = 0;
         cur_wait  = $urandom_range(max_wait, min_wait);
         bus_ack_i = stray_ack;
      end
   end

   logic        prev_req = 0;
   bit          bseen = 0;
   int          blen = 0, last_len = 0;
   logic [68:0] snap = 0;

   task automatic cmp_resp(input string who, input exp_t e, input logic err, input logic [31:0] rd);
      check({who, "_err"}, 69'(err), 69'(e.err));
      check({who, "_rdata"}, 69'(rd), 69'(e.rdata));
      if (e.has_bus) begin
         check({who, "_bus_cycle"}, 69'(bseen), 69'd1);
         check({who, "_bus_we_addr_be"}, 69'(snap[68:32]), 69'({e.we, e.addr, e.be}));
         if (e.we) check({who, "_bus_wdata"}, 69'(snap[31:0]), 69'(e.wdata));
         if (e.dead) check({who, "_timeout_len"}, 69'(last_len), 69'(TIMEOUT));
      end else begin
         check({who, "_no_bus"}, 69'(bseen), 69'd0);
      end
      bseen = 0;
   endtask

   always @(negedge clk_i) begin
      exp_t e;
      if (rst_i) begin
         prev_req = 0;
         bseen    = 0;
         blen     = 0;
      end else begin
         if (bus_req_o) begin
            if (!prev_req) begin
               snap = {bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o};
               blen = 1;
            end else begin
               blen++;
               check("bus_stable", {bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o}, snap);
            end
         end else if (prev_req) begin
            bseen    = 1;
            last_len = blen;
         end
         prev_req = bus_req_o;

         if (d_ack_o) begin
            glog.push_back(GD);
            if (dq.size() == 0) begin
               unexp_acks++;
               check("unexpected_d_ack", 69'd1, 69'd0);
            end else begin
               e = dq.pop_front();
               cmp_resp("d", e, d_err_o, d_rdata_o);
            end
         end else check("d_quiet", 69'({d_err_o, d_rdata_o}), 69'd0);

         if (if_ack_o) begin
            glog.push_back(GF);
            if (fq.size() == 0) begin
               unexp_acks++;
               check("unexpected_if_ack", 69'd1, 69'd0);
            end else begin
               e = fq.pop_front();
               cmp_resp("if", e, if_err_o, if_rdata_o);
            end
         end else check("if_quiet", 69'({if_err_o, if_rdata_o}), 69'd0);

         check("stallreq", 69'(stallreq_o), 69'(d_req_i & ~d_ack_o));
      end
   end

   task automatic d_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w,
                          output int lat);
      dq.push_back(model_d(op, a, w));
      d_req_i = 1; d_op_i = op; d_addr_i = a; d_wdata_i = w;
      d_we_i  = (op >= 6 && op <= 8);
      lat = 0;
      do begin
         @(negedge clk_i);
         lat++;
      end while (!d_ack_o && lat < 200);
      check("d_ack_seen", 69'(d_ack_o), 69'd1);
      @(posedge clk_i); #1;
      d_req_i = 0;
   endtask

   task automatic f_issue(input logic [31:0] a, output int lat);
      fq.push_back(model_f(a));
      if_req_i = 1; if_addr_i = a;
      lat = 0;
      do begin
         @(negedge clk_i);
         lat++;
      end while (!if_ack_o && lat < 200);
      check("if_ack_seen", 69'(if_ack_o), 69'd1);
      @(posedge clk_i); #1;
      if_req_i = 0;
   endtask

   function automatic logic [68:0] all_outs();
      return 69'({if_ack_o, if_err_o, d_ack_o, d_err_o, bus_req_o, bus_we_o, stallreq_o,
                  (|if_rdata_o), (|d_rdata_o), (|bus_addr_o), (|bus_be_o), (|bus_wdata_o)});
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, base, cnt, ua;
      byte exp_seq[10];
      exp_seq = '{GD, GD, GD, GD, GF, GD, GD, GD, GD, GF};

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("reset_outputs", all_outs(), 69'd0);
      @(posedge clk_i); #1;
      rst_i = 0;

      // Zero-wait word load, three-cycle latency.
      force_en = 1; force_val = 32'hDEADBEEF;
      d_issue(4'd3, 32'h100, 32'h0, lat);
      check("lw_latency", 69'(lat), 69'd3);

      // Byte loads from the top lane and a halfword store to the upper half.
      force_val = 32'h80FFFF7F;
      d_issue(4'd1, 32'h103, 32'h0, lat);
      d_issue(4'd4, 32'h103, 32'h0, lat);
      d_issue(4'd7, 32'h102, 32'h1234, lat);
      force_en = 0;

      // Misaligned word access short-circuits to an error response.
      d_issue(4'd3, 32'h101, 32'h0, lat);
      check("misaligned_latency", 69'(lat), 69'd2);

      // Dead bus: both ports time out, later stray acks are ignored.
      bus_dead = 1;
      d_issue(4'd3, 32'h200, 32'h0, lat);
      f_issue(32'h300, lat);
      bus_dead = 0;
      ua = unexp_acks;
      stray_ack = 1;
      repeat (5) @(posedge clk_i);
      #1 stray_ack = 0;
      repeat (2) @(posedge clk_i);
      #1 check("stray_ack_ignored", 69'(unexp_acks), 69'(ua));

      // Reset on the third bus cycle of a slow access.
      min_wait = 10; max_wait = 10;
      d_req_i = 1; d_op_i = 4'd3; d_addr_i = 32'h400; d_we_i = 0;
      cnt = 0;
      for (int i = 0; i < 50 && cnt < 3; i++) begin
         @(negedge clk_i);
         if (bus_req_o) cnt++;
      end
      check("reached_third_xfer", 69'(cnt), 69'd3);
      #1 rst_i = 1; d_req_i = 0;
      @(negedge clk_i);
      check("mid_xfer_reset_outputs", all_outs(), 69'd0);
      @(posedge clk_i); #1;
      rst_i = 0;
      min_wait = 0; max_wait = 0;
      d_issue(4'd3, 32'h404, 32'h0, lat);
      check("after_reset_latency", 69'(lat), 69'd3);

      // Fairness with both requesters held continuously.
      base = glog.size();
      max_wait = 2;
      fork
         begin
            int l;
            for (int i = 0; i < 8; i++) d_issue(4'd3, 32'h1000 + 32'(i) * 4, 32'h0, l);
         end
         begin
            int l;
            for (int i = 0; i < 2; i++) f_issue(32'h2000 + 32'(i) * 4, l);
         end
      join
      check("grant_count", 69'(glog.size() - base), 69'd10);
      for (int i = 0; i < 10; i++)
         if (base + i < glog.size())
            check($sformatf("grant_order_%0d", i), 69'(glog[base + i]), 69'(exp_seq[i]));

      // Randomized mixed traffic.
      max_wait = 3;
      fork
         begin
            int l, g;
            logic [3:0] op;
            for (int i = 0; i < 60; i++) begin
               op = ($urandom_range(9, 0) == 0) ? 4'($urandom_range(15, 0))
                                                : 4'($urandom_range(8, 1));
               d_issue(op, $urandom, $urandom, l);
               g = $urandom_range(3, 0);
               if (g > 0) begin
                  repeat (g) @(posedge clk_i);
                  #1;
               end
            end
         end
         begin
            int l, g;
            for (int i = 0; i < 30; i++) begin
               f_issue($urandom, l);
               g = $urandom_range(4, 0);
               if (g > 0) begin
                  repeat (g) @(posedge clk_i);
                  #1;
               end
            end
         end
      join
      repeat (3) @(posedge clk_i);
      #1;
      check("d_queue_drained", 69'(dq.size()), 69'd0);
      check("if_queue_drained", 69'(fq.size()), 69'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
